// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request, memory and response signals of mem_access_ctrl.
//   slave  : the controller itself (accepts requests, strobes memory, responds)
//   master : the environment (issues requests, models memory, takes responses)
interface mem_access_ctrl_if #(
  parameter int SIZE = 32
);
  // request channel
  logic                  reqValid;
  logic                  reqWrite;
  logic [2*SIZE-1:0]     reqAddr1;
  logic [2*SIZE-1:0]     reqAddr2;
  logic                  reqReady;
  // memory channel
  logic                  memEnable;
  logic                  memoryControl;
  logic [2*SIZE-1:0]     data1;
  logic [2*SIZE-1:0]     data2;
  logic                  memDone;
  logic [2*SIZE-1:0]     dataOutput1;
  logic [2*SIZE-1:0]     dataOutput2;
  // response channel
  logic                  rspValid;
  logic [SIZE-1:0]       rspData1;
  logic [SIZE-1:0]       rspData2;
  logic                  rspError;

  modport slave (
    input  reqValid, reqWrite, reqAddr1, reqAddr2,
    output reqReady,
    output memEnable, memoryControl, data1, data2,
    input  memDone, dataOutput1, dataOutput2,
    output rspValid, rspData1, rspData2, rspError
  );

  modport master (
    output reqValid, reqWrite, reqAddr1, reqAddr2,
    input  reqReady,
    input  memEnable, memoryControl, data1, data2,
    output memDone, dataOutput1, dataOutput2,
    input  rspValid, rspData1, rspData2, rspError
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request memory access controller.
// Accepts one read (two addresses) or write request at a time, range-checks it,
// strobes memory with a fresh memEnable rising edge, waits at least MIN_WAIT
// cycles for memDone (giving up after TIMEOUT cycles) and returns a one-cycle
// response pulse.
// Build option: define MEM_ACCESS_STATS_EN to enable the saturating
// readCount/writeCount/errorCount statistics; otherwise they are tied to 0.
module mem_access_ctrl #(
  parameter int SIZE      = 32,
  parameter int MAX_RANGE = 10,
  parameter int MIN_WAIT  = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             resetN,
  mem_access_ctrl_if.slave bus,
  output logic             busy,
  output logic [15:0]      readCount,
  output logic [15:0]      writeCount,
  output logic [15:0]      errorCount
);

  localparam int AW = 2 * SIZE;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [AW-1:0] ADDR_LIMIT = AW'(MAX_RANGE);
  localparam logic [CW-1:0] DONE_MIN   = (MIN_WAIT > 0) ? CW'(MIN_WAIT - 1) : '0;
  localparam logic [CW-1:0] CNT_LAST   = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          ready_q;      // low in reset, high from the first edge after release
  logic          req_ready;
  logic          accept;
  logic          range_err;
  logic          err_q;        // accepted request failed the range check
  logic [CW-1:0] wait_cnt;
  logic          complete;
  logic          expired;

  logic          mem_en_q;
  logic          mem_ctl_q;
  logic [AW-1:0] data1_q;
  logic [AW-1:0] data2_q;

  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [SIZE-1:0] rsp_d1_q;
  logic [SIZE-1:0] rsp_d2_q;

  // Only the low half of each read word is returned.
  logic unused_hi;
  assign unused_hi = &{1'b0, bus.dataOutput1[AW-1:SIZE], bus.dataOutput2[AW-1:SIZE]};

  assign req_ready = ready_q && (state == IDLE);
  assign accept    = bus.reqValid && req_ready;

  // A write only carries an address on reqAddr2; reqAddr1 is its data.
  assign range_err = (bus.reqAddr2 >= ADDR_LIMIT) ||
                     (!bus.reqWrite && (bus.reqAddr1 >= ADDR_LIMIT));

  // memDone is ignored until the minimum wait has elapsed; a success in the
  // last allowed cycle wins over the timeout.
  assign complete = (state == WAIT) && (wait_cnt >= DONE_MIN) && bus.memDone;
  assign expired  = (state == WAIT) && (wait_cnt >= CNT_LAST);

  // Next-state logic. An illegal request uses the post-accept cycle without
  // strobing memory and then reports straight from DONE.
  always_comb begin
    // NOTE: assign a default before the case so every path drives state_nxt;
    // a missing assignment on any branch would infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = err_q ? DONE : WAIT;
      WAIT:    if (complete || expired) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Ready enable: keeps reqReady low while in reset even though state is IDLE.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) ready_q <= 1'b0;
    else         ready_q <= 1'b1;
  end

  // Capture the accepted request; these drive memory for the whole operation.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      data1_q   <= '0;
      data2_q   <= '0;
      mem_ctl_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      data1_q   <= bus.reqAddr1;
      data2_q   <= bus.reqAddr2;
      mem_ctl_q <= bus.reqWrite;
      err_q     <= range_err;
    end
  end

  // WAIT cycle counter: 0 in the first WAIT cycle, cleared elsewhere.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)              wait_cnt <= '0;
    else if (state == WAIT)   wait_cnt <= wait_cnt + CW'(1);
    else                      wait_cnt <= '0;
  end

  // Memory strobe: high exactly while in WAIT, so it rises one cycle after
  // data1/data2/memoryControl settle and is low through DONE and IDLE.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) mem_en_q <= 1'b0;
    else         mem_en_q <= (state_nxt == WAIT);
  end

  // Response: one-cycle pulse in DONE; read data captured only on a
  // successful read, otherwise the previous result is held.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_d1_q    <= '0;
      rsp_d2_q    <= '0;
    end else begin
      rsp_valid_q <= (state_nxt == DONE);
      if (state_nxt == DONE)
        rsp_err_q <= (state == ISSUE) ? err_q : !complete;
      if (complete && !mem_ctl_q) begin
        rsp_d1_q <= bus.dataOutput1[SIZE-1:0];
        rsp_d2_q <= bus.dataOutput2[SIZE-1:0];
      end
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] er_cnt;

  // Saturating statistics, classified on each response pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      er_cnt <= '0;
    end else if (rsp_valid_q) begin
      if (rsp_err_q) begin
        if (er_cnt != 16'hFFFF) er_cnt <= er_cnt + 16'd1;
      end else if (mem_ctl_q) begin
        if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      end else begin
        if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

  assign readCount  = rd_cnt;
  assign writeCount = wr_cnt;
  assign errorCount = er_cnt;
`else
  assign readCount  = '0;
  assign writeCount = '0;
  assign errorCount = '0;
`endif

  assign bus.reqReady      = req_ready;
  assign bus.memEnable     = mem_en_q;
  assign bus.memoryControl = mem_ctl_q;
  assign bus.data1         = data1_q;
  assign bus.data2         = data2_q;
  assign bus.rspValid      = rsp_valid_q;
  assign bus.rspError      = rsp_err_q;
  assign bus.rspData1      = rsp_d1_q;
  assign bus.rspData2      = rsp_d2_q;
  assign busy              = (state != IDLE);

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: SIZE, default 32, data half-width; MAX_RANGE, default 10, number of valid memory words; MIN_WAIT, default 4, minimum WAIT cycles before memDone counts; TIMEOUT, default 64, maximum WAIT cycles.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be (name direction width meaning):
  clk  in  1  clock, rising edge
  resetN  in  1  async active-low reset
  reqValid  in  1  pipeline request present
  reqWrite  in  1  0 = dual read, 1 = write
  reqAddr1  in  SIZE*2  read address 1 / write data
  reqAddr2  in  SIZE*2  read address 2 / write address
  reqReady  out  1  request may be accepted
  memEnable  out  1  memory strobe; rising edge starts operation
  memoryControl  out  1  0 = read, 1 = write
  data1  out  SIZE*2  to memory: address 1 / write data
  data2  out  SIZE*2  to memory: address 2 / write address
  memDone  in  1  memory completion flag; sticky high once set
  dataOutput1  in  SIZE*2  read data 1 from memory
  dataOutput2  in  SIZE*2  read data 2 from memory
  rspValid  out  1  one-cycle response pulse
  rspData1  out  SIZE  read result 1
  rspData2  out  SIZE  read result 2
  rspError  out  1  range or timeout error; valid with rspValid
  busy  out  1  state is not IDLE
  readCount, writeCount, errorCount  out  16 each  statistics

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-005 reqReady SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge with reqValid=1 and reqReady=1; reqValid is ignored otherwise.
REQ-006 On acceptance, the block SHALL register data1=reqAddr1, data2=reqAddr2, memoryControl=reqWrite, and go to ISSUE with memEnable=0.
REQ-007 Range check on acceptance: read is illegal if reqAddr1>=MAX_RANGE or reqAddr2>=MAX_RANGE; write is illegal if reqAddr2>=MAX_RANGE; an illegal request SHALL skip ISSUE/WAIT, go to DONE with rspError=1, and never assert memEnable.
REQ-008 ISSUE->WAIT after one cycle; memEnable SHALL rise on entry to WAIT (one cycle after data1/data2/memoryControl are stable) and stay high through WAIT.
REQ-009 In WAIT, a counter SHALL start at 0 and increment each cycle; completion SHALL occur when counter>=MIN_WAIT-1 and memDone=1.
REQ-010 On completion, for a read, rspData1=dataOutput1[SIZE-1:0] and rspData2=dataOutput2[SIZE-1:0] SHALL be captured; for a write, rspData1/rspData2 SHALL hold their previous values; then go to DONE with rspError=0.
REQ-011 If counter reaches TIMEOUT-1 without completion, the block SHALL go to DONE with rspError=1.
REQ-012 In DONE, memEnable SHALL be 0 and rspValid SHALL be 1 for exactly one cycle; next state SHALL be IDLE.
REQ-013 Request-accept edge to rspValid latency SHALL be MIN_WAIT+2 cycles minimum, 2 cycles for range errors.
REQ-014 memEnable SHALL be low for at least two cycles (DONE, IDLE) between consecutive operations, guaranteeing a fresh rising edge.
REQ-015 busy SHALL equal (state != IDLE).

Reset
REQ-016 While resetN=0, the block SHALL force state=IDLE and drive memEnable, memoryControl, data1, data2, rspValid, rspData1, rspData2, rspError, busy, and all counters to 0; reqReady SHALL be 0 while resetN=0 and 1 from the first edge after release.
REQ-017 A reset mid-operation SHALL drop memEnable immediately and SHALL produce no rspValid for the aborted request.

Configuration
REQ-018 With MEM_ACCESS_STATS_EN defined, readCount, writeCount, and errorCount SHALL increment on each rspValid by type (errorCount when rspError=1; otherwise read or write) and SHALL saturate at 16'hFFFF; without the macro, these ports SHALL remain present and be tied to 0.

Verification
REQ-019 Read with reqAddr1=2, reqAddr2=5 and memory returning 64'h0000_0000_1234_5678 and 64'h0000_0000_0000_00AA -> memEnable rises 1 cycle after accept; rspValid after MIN_WAIT+2 cycles; rspData1=32'h12345678, rspData2=32'h000000AA, rspError=0.
REQ-020 Write with reqAddr1=64'h55, reqAddr2=3 -> memoryControl=1, data1=64'h55, data2=3 at the memEnable rising edge; rspValid with rspError=0.
REQ-021 Read with reqAddr2=10 (MAX_RANGE=10) -> memEnable never rises; rspValid 2 cycles after accept with rspError=1.
REQ-022 memDone held 0 -> rspValid with rspError=1 at WAIT cycle 64; memEnable returns to 0.
REQ-023 resetN asserted in WAIT cycle 2 -> memEnable=0 at once, no rspValid; after release reqReady=1 and the next read completes normally.
REQ-024 With MEM_ACCESS_STATS_EN, 2 reads, 1 write and 1 range error -> readCount=2, writeCount=1, errorCount=1; without the macro all counters read 0.
